attex_bus_ctrl: RTL and testbench

// - Bus cycle controller for the SCC68070 CPU bus on the CD-i MONO board.
// - Decodes each CPU cycle into one device region, drives the chip selects, and sequences the cycle.
// - Sequencing covers wait states, device ack and edge-detected slave DTACK, ending in a single bus_ack or bus_err.
// - Also generates the delayed IRQ pulse to the 68HC05 slave after each slave access.
// - Sits between the CPU bus pins and the MCD212, CDIC, slave-uC and NVRAM select/ack lines.

---
 rtl/attex_pkg.sv | 31 +++
 rtl/attex_addr_decode.sv | 28 ++
 rtl/attex_bus_ctrl.sv | 125 ++++++++++++
 tb/tb_attex_bus_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/attex_pkg.sv
// rtl/attex_pkg.sv - region/state types and CPU address map shared by the SCC68070 bus controller
package attex_pkg;

  typedef enum logic [2:0] {
    REG_UNMAPPED,
    REG_MCD212,
    REG_CDIC,
    REG_SLAVE,
    REG_NVRAM,
    REG_BERR
  } region_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACCESS  = 2'd1;
  localparam state_t ST_ACK     = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  // Byte-address map; the CPU presents word addresses, bit 0 is implied zero.
  localparam logic [23:0] BERR_LO     = 24'h600000;
  localparam logic [23:0] BERR_HI     = 24'hCFFFFF;
  localparam logic [23:0] BERR_TOP    = 24'hF00000;
  localparam logic [23:0] MCD_LOW_HI  = 24'h27FFFF;
  localparam logic [23:0] MCD_HIGH_LO = 24'h400000;
  localparam logic [23:0] MCD_HIGH_HI = 24'h7FFFFF;
  localparam logic [7:0]  CDIC_PAGE   = 8'h30;
  localparam logic [7:0]  SLAVE_PAGE  = 8'h31;
  localparam logic [7:0]  NVRAM_PAGE  = 8'h32;

endpackage

// File: rtl/attex_addr_decode.sv
// rtl/attex_addr_decode.sv - combinational CPU word address to device region decode
module attex_addr_decode
  import attex_pkg::*;
(
  input  logic [23:1] addr,
  output region_t     region
);

  logic [23:0] byte_addr;

  assign byte_addr = {addr, 1'b0};

  // Bus-error windows overlap the upper MCD212 window, so they are tested first.
  always_comb begin
    region = REG_UNMAPPED;
    if ((byte_addr >= BERR_LO && byte_addr <= BERR_HI) || byte_addr >= BERR_TOP)
      region = REG_BERR;
    else if (byte_addr[23:16] == CDIC_PAGE)
      region = REG_CDIC;
    else if (byte_addr[23:16] == SLAVE_PAGE)
      region = REG_SLAVE;
    else if (byte_addr[23:16] == NVRAM_PAGE)
      region = REG_NVRAM;
    else if (byte_addr <= MCD_LOW_HI || (byte_addr >= MCD_HIGH_LO && byte_addr <= MCD_HIGH_HI))
      region = REG_MCD212;
  end

endmodule

// File: rtl/attex_bus_ctrl.sv
// rtl/attex_bus_ctrl.sv - SCC68070 bus cycle controller: decode, chip selects, ack/err sequencing, slave IRQ
// Optional access watchdog enabled by defining ATTEX_BUS_TIMEOUT_EN.
module attex_bus_ctrl
  import attex_pkg::*;
#(
  parameter int WAIT_CDIC   = 2,
  parameter int WAIT_NVRAM  = 1,
  parameter int IRQ_DELAY   = 20,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:1] addr,
  input  logic        as,
  input  logic        uds,
  input  logic        lds,
  input  logic        write_strobe,
  input  logic        mcd212_ack,
  input  logic        slave_dtack_n,
  output logic        cs_mcd212,
  output logic        cs_cdic,
  output logic        cs_slave,
  output logic        cs_nvram,
  output logic        bus_ack,
  output logic        bus_err,
  output logic        nvram_we,
  output logic        slave_irq
);

  state_t      state, state_nxt;
  region_t     region_d, region_q;
  logic [7:0]  wait_cnt, wait_load;
  logic [15:0] irq_cnt;
  logic        dtack_q;
  logic        start, in_access, active, done, timeout;

  attex_addr_decode u_decode (
    .addr   (addr),
    .region (region_d)
  );

  assign start     = (state == ST_IDLE) && as && (uds || lds);
  assign in_access = (state == ST_ACCESS);
  assign active    = (state != ST_IDLE);

  always_comb begin
    wait_load = 8'd0;
    if (region_d == REG_CDIC)  wait_load = 8'(WAIT_CDIC);
    if (region_d == REG_NVRAM) wait_load = 8'(WAIT_NVRAM);
  end

  always_comb begin
    done = 1'b0;
    case (region_q)
      REG_MCD212: done = mcd212_ack;
      REG_SLAVE:  done = slave_dtack_n && !dtack_q;
      REG_BERR:   done = 1'b0;
      default:    done = (wait_cnt == 8'd0);
    endcase
  end

`ifdef ATTEX_BUS_TIMEOUT_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)       wd_cnt <= '0;
    else if (start)     wd_cnt <= '0;
    else if (in_access) wd_cnt <= wd_cnt + 16'd1;
  end

  assign timeout = (wd_cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // A strobe drop always wins; completion beats a same-cycle timeout.
  assign bus_err = in_access && as && ((region_q == REG_BERR) || (timeout && !done));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (!as)          state_nxt = ST_IDLE;
        else if (bus_err) state_nxt = ST_RELEASE;
        else if (done)    state_nxt = ST_ACK;
      end
      ST_ACK:     state_nxt = ST_RELEASE;
      ST_RELEASE: if (!as) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      region_q <= REG_UNMAPPED;
      wait_cnt <= 8'd0;
      dtack_q  <= 1'b1;
      irq_cnt  <= 16'd0;
    end else begin
      state   <= state_nxt;
      dtack_q <= slave_dtack_n;
      if (start) begin
        region_q <= region_d;
        wait_cnt <= wait_load;
      end else if (in_access && wait_cnt != 8'd0) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
      if (start && region_d == REG_SLAVE)
        irq_cnt <= 16'(IRQ_DELAY);
      else if (irq_cnt != 16'd0)
        irq_cnt <= irq_cnt - 16'd1;
    end
  end

  assign cs_mcd212 = active && (region_q == REG_MCD212);
  assign cs_cdic   = active && (region_q == REG_CDIC);
  assign cs_slave  = active && (region_q == REG_SLAVE);
  assign cs_nvram  = active && (region_q == REG_NVRAM);
  assign bus_ack   = (state == ST_ACK);
  assign nvram_we  = bus_ack && (region_q == REG_NVRAM) && uds && write_strobe;
  assign slave_irq = (irq_cnt == 16'd1);

endmodule

// File: tb/tb_attex_bus_ctrl.sv
// tb/tb_attex_bus_ctrl.sv - scoreboard bench for attex_bus_ctrl
module tb_attex_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:1] addr = '0;
  logic        as = 1'b0, uds = 1'b0, lds = 1'b0, write_strobe = 1'b0;
  logic        mcd212_ack = 1'b0, slave_dtack_n = 1'b1;
  logic        cs_mcd212, cs_cdic, cs_slave, cs_nvram;
  logic        bus_ack, bus_err, nvram_we, slave_irq;

  typedef struct {
    bit err;
    bit we;
    int lat;
  } resp_t;

  typedef struct {
    logic [23:0] a;
    bit          u, l, w, mack;
    logic [3:0]  cs;
    bit          err, we;
    int          lat;
  } acc_t;

  resp_t exp_q[$];
  resp_t got;
  int    errors = 0, checks = 0, cyc = 0, start_cyc = 0;

  attex_bus_ctrl #(
    .WAIT_CDIC(2), .WAIT_NVRAM(1), .IRQ_DELAY(20), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .as(as), .uds(uds), .lds(lds),
    .write_strobe(write_strobe), .mcd212_ack(mcd212_ack), .slave_dtack_n(slave_dtack_n),
    .cs_mcd212(cs_mcd212), .cs_cdic(cs_cdic), .cs_slave(cs_slave), .cs_nvram(cs_nvram),
    .bus_ack(bus_ack), .bus_err(bus_err), .nvram_we(nvram_we), .slave_irq(slave_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every ack/err pulse must match the oldest expected response, including its latency.
  always @(negedge clk) begin
    if (bus_ack || bus_err) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b at cycle %0d, required no response",
                 bus_ack, bus_err, cyc - start_cyc);
      end else begin
        got = exp_q.pop_front();
        if (bus_err !== got.err || nvram_we !== got.we || (cyc - start_cyc) != got.lat) begin
          errors++;
          $display("FAIL resp: err=%0b we=%0b lat=%0d, required err=%0b we=%0b lat=%0d",
                   bus_err, nvram_we, cyc - start_cyc, got.err, got.we, got.lat);
        end
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, nvram_we, slave_irq} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, nvram_we, slave_irq});
    end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_regions();
    acc_t tbl[14] = '{
      '{24'h300010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4},
      '{24'h320000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 3},
      '{24'h320000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 3},
      '{24'h320000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 3},
      '{24'h600000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1},
      '{24'hF00000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1},
      '{24'hCFFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1},
      '{24'h7FFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1},
      '{24'h27FFFE, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 2},
      '{24'h400000, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 2},
      '{24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 2},
      '{24'h280000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2},
      '{24'hEFFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2},
      '{24'h330000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2}
    };
    foreach (tbl[i]) begin
      @(negedge clk);
      #1;
      exp_q.push_back('{tbl[i].err, tbl[i].we, tbl[i].lat});
      addr = tbl[i].a[23:1];
      uds = tbl[i].u; lds = tbl[i].l; write_strobe = tbl[i].w; mcd212_ack = tbl[i].mack;
      as = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      checks++;
      if ({cs_mcd212, cs_cdic, cs_slave, cs_nvram} !== tbl[i].cs) begin
        errors++;
        $display("FAIL cs_decode %h: got %b, required %b", tbl[i].a,
                 {cs_mcd212, cs_cdic, cs_slave, cs_nvram}, tbl[i].cs);
      end
      repeat (tbl[i].lat - 1) @(negedge clk);
      #1 as = 1'b0; uds = 1'b0; lds = 1'b0; write_strobe = 1'b0; mcd212_ack = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cs_mcd212, cs_cdic, cs_slave, cs_nvram} !== 4'b0000) begin
        errors++;
        $display("FAIL cs_idle %h: got %b, required 0000", tbl[i].a,
                 {cs_mcd212, cs_cdic, cs_slave, cs_nvram});
      end
    end
  endtask

  task automatic test_slave();
    logic [23:0] ba = 24'h310002;
    @(negedge clk);
    #1;
    exp_q.push_back('{1'b0, 1'b0, 6});
    addr = ba[23:1]; uds = 1'b1; lds = 1'b1; slave_dtack_n = 1'b1; as = 1'b1;
    start_cyc = cyc;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      checks++;
      if (slave_irq !== (k == 20)) begin
        errors++;
        $display("FAIL slave_irq cycle %0d: got %b, required %b", k, slave_irq, (k == 20));
      end
      if (k <= 6) begin
        checks++;
        if (cs_slave !== 1'b1) begin
          errors++;
          $display("FAIL cs_slave cycle %0d: got %b, required 1", k, cs_slave);
        end
      end
      #1;
      if (k == 2)  slave_dtack_n = 1'b0;
      if (k == 5)  slave_dtack_n = 1'b1;
      if (k == 6)  begin as = 1'b0; uds = 1'b0; lds = 1'b0; end
      if (k == 10) slave_dtack_n = 1'b0;
      if (k == 12) slave_dtack_n = 1'b1;
    end
  endtask

  task automatic test_mcd212();
    logic [23:0] ba = 24'h400000;
    @(negedge clk);
    #1 addr = ba[23:1]; uds = 1'b1; mcd212_ack = 1'b0; as = 1'b1; start_cyc = cyc;
    repeat (3) @(negedge clk);
    checks++;
    if (cs_mcd212 !== 1'b1) begin
      errors++;
      $display("FAIL mcd_wait_cs: got %b, required 1", cs_mcd212);
    end
    #1 as = 1'b0;
    @(negedge clk);
    checks++;
    if (cs_mcd212 !== 1'b0) begin
      errors++;
      $display("FAIL mcd_abort_idle: got %b, required 0", cs_mcd212);
    end
    #1;
    exp_q.push_back('{1'b0, 1'b0, 4});
    as = 1'b1; start_cyc = cyc;
    repeat (3) @(negedge clk);
    #1 mcd212_ack = 1'b1;
    @(negedge clk);
    #1 mcd212_ack = 1'b0; as = 1'b0; uds = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [23:0] ba = 24'h300010;
    logic [23:0] bu = 24'h280000;
    @(negedge clk);
    #1;
    exp_q.push_back('{1'b0, 1'b0, 4});
    addr = ba[23:1]; uds = 1'b1; lds = 1'b1; as = 1'b1; start_cyc = cyc;
    repeat (8) @(negedge clk);
    checks++;
    if (cs_cdic !== 1'b1) begin
      errors++;
      $display("FAIL release_hold: got %b, required 1", cs_cdic);
    end
    #1 as = 1'b0;
    @(negedge clk);
    checks++;
    if (cs_cdic !== 1'b0) begin
      errors++;
      $display("FAIL release_drop: got %b, required 0", cs_cdic);
    end
    #1;
    exp_q.push_back('{1'b0, 1'b0, 2});
    addr = bu[23:1]; as = 1'b1; start_cyc = cyc;
    repeat (2) @(negedge clk);
    #1 as = 1'b0; uds = 1'b0; lds = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_watchdog();
    logic [23:0] ba = 24'h400000;
    int          hold;
    @(negedge clk);
    #1;
`ifdef ATTEX_BUS_TIMEOUT_EN
    exp_q.push_back('{1'b1, 1'b0, 16});
    hold = 16;
`else
    hold = 40;
`endif
    addr = ba[23:1]; uds = 1'b1; mcd212_ack = 1'b0; as = 1'b1; start_cyc = cyc;
    repeat (hold) @(negedge clk);
    checks++;
    if (cs_mcd212 !== 1'b1) begin
      errors++;
      $display("FAIL watchdog_cs: got %b, required 1", cs_mcd212);
    end
    #1 as = 1'b0; uds = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [23:0] ba = 24'h400000;
    @(negedge clk);
    #1 addr = ba[23:1]; uds = 1'b1; as = 1'b1; start_cyc = cyc;
    repeat (2) @(negedge clk);
    checks++;
    if (cs_mcd212 !== 1'b1) begin
      errors++;
      $display("FAIL mid_cs: got %b, required 1", cs_mcd212);
    end
    #1 reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, nvram_we, slave_irq} !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got %b, required 00000000",
               {cs_mcd212, cs_cdic, cs_slave, cs_nvram, bus_ack, bus_err, nvram_we, slave_irq});
    end
    #1 reset_n = 1'b1; as = 1'b0; uds = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      begin
        #100000;
        $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
        $fatal(1, "bench timeout");
      end
    join_none
    test_reset();
    test_regions();
    test_slave();
    test_mcd212();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_resp: %0d outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
